// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU and debug-port accesses onto the single unified
// memory. One access at a time: IDLE picks an owner, ACC issues a one-cycle
// strobe and waits out the read latency, RESP returns a one-cycle ready pulse.
module mem_arbiter #(
   parameter int RD_LAT  = 1,   // memory cycles from strobe to valid mem_rddata (1..15)
   parameter int RR_MODE = 0    // 0: debug has fixed priority, 1: round-robin on ties
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_wrbits,
   input  logic [31:0] cpu_wrdata,
   output logic [31:0] cpu_rddata,
   output logic        cpu_ready,
   output logic        cpu_stall,

   input  logic        dbg_req,
   input  logic        dbg_write,
   input  logic [31:0] dbg_addr,
   input  logic [3:0]  dbg_wrbits,
   input  logic [31:0] dbg_wrdata,
   output logic [31:0] dbg_rddata,
   output logic        dbg_ready,

   output logic        cpu_gnt,
   output logic        dbg_gnt,

   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_wrbits,
   output logic [31:0] mem_wrdata,
   input  logic [31:0] mem_rddata
);

   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   // ACC lasts RD_LAT cycles; the counter starts one below so that the
   // cycle in which it reads zero is the last ACC cycle.
   localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        owner_dbg;     // 1: the debug port owns the current access
   logic        last_dbg;      // owner of the most recent grant, for round-robin
   logic        lat_write;     // latched direction of the current access

   logic        pick_dbg;
   logic        sel_write;
   logic [31:0] sel_addr;
   logic [3:0]  sel_wrbits;
   logic [31:0] sel_wrdata;

   // Owner selection for a grant in IDLE, and mux of the winner's request fields.
   always_comb begin
      pick_dbg = 1'b0;
      if (RR_MODE == 0) begin
         pick_dbg = dbg_req;
      end else begin
         // A lone requester wins; on a tie the one that was not served last wins.
         pick_dbg = dbg_req & (~cpu_req | ~last_dbg);
      end
      sel_write  = pick_dbg ? dbg_write  : cpu_write;
      sel_addr   = pick_dbg ? dbg_addr   : cpu_addr;
      sel_wrbits = pick_dbg ? dbg_wrbits : cpu_wrbits;
      sel_wrdata = pick_dbg ? dbg_wrdata : cpu_wrdata;
   end

   // Arbitration FSM; every output apart from cpu_stall is a register here.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         owner_dbg  <= 1'b0;
         last_dbg   <= 1'b1;
         lat_write  <= 1'b0;
         cpu_gnt    <= 1'b0;
         dbg_gnt    <= 1'b0;
         cpu_ready  <= 1'b0;
         dbg_ready  <= 1'b0;
         cpu_rddata <= 32'd0;
         dbg_rddata <= 32'd0;
         mem_addr   <= 32'd0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_wrbits <= 4'd0;
         mem_wrdata <= 32'd0;
      end else begin
         // Strobes and ready are single-cycle pulses unless set below.
         cpu_ready <= 1'b0;
         dbg_ready <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req | dbg_req) begin
                  owner_dbg  <= pick_dbg;
                  last_dbg   <= pick_dbg;
                  cpu_gnt    <= ~pick_dbg;
                  dbg_gnt    <= pick_dbg;
                  lat_write  <= sel_write;
                  // The memory-side registers double as the transaction latch
                  // and keep their values after the access ends.
                  mem_addr   <= sel_addr;
                  mem_wrbits <= sel_write ? sel_wrbits : 4'd0;
                  mem_wrdata <= sel_wrdata;
                  mem_read   <= ~sel_write;
                  mem_write  <= sel_write;
                  cnt        <= CNT_INIT;
                  state      <= ACC;
               end
            end
            ACC: begin
               if (cnt == 4'd0) begin
                  if (!lat_write) begin
                     if (owner_dbg) dbg_rddata <= mem_rddata;
                     else           cpu_rddata <= mem_rddata;
                  end
                  if (owner_dbg) dbg_ready <= 1'b1;
                  else           cpu_ready <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               cpu_gnt <= 1'b0;
               dbg_gnt <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Hold the CPU phase until its access has completed.
   assign cpu_stall = cpu_req & ~cpu_ready;

endmodule
